// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - state encoding and parameter defaults for the pipeline stall controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int CNT_W_DEF       = 32;
  localparam int MEM_TIMEOUT_DEF = 64;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that holds at MAX instead of wrapping
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - per-stage write-enable/bubble decode for a 5-stage pipe with memory freeze
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_stall_i,
  input  logic             branch_flush_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_bubble_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic             mem_err_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              err_q;
  logic              err_set;
  logic              release_pipe;
  logic [WAIT_W-1:0] wait_cnt;

  always_comb begin
    state_d         = state_q;
    err_set         = 1'b0;
    release_pipe    = 1'b0;
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_write_o  = 1'b0;
    mem_wb_bubble_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          mem_wb_bubble_o = 1'b1;
          state_d         = ST_MEM_WAIT;
        end else begin
          release_pipe = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          release_pipe = 1'b1;
          state_d      = ST_RUN;
        end else if (!mem_req_i) begin
          // Requester abandoned the access: flag it and let the pipe move on.
          err_set      = 1'b1;
          release_pipe = 1'b1;
          state_d      = ST_RUN;
        end else begin
          mem_wb_bubble_o = 1'b1;
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) err_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load-use stall outranks the branch flush because the branch operand is not yet valid.
    if (release_pipe) begin
      ex_mem_write_o = 1'b1;
      if (hazard_stall_i) begin
        id_ex_bubble_o = 1'b1;
      end else begin
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
        if_id_flush_o = branch_flush_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | err_set;
    end
  end

  assign mem_err_o = err_q | err_set;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (1'b0),
    .inc_i   (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_write_o),
    .count_o (stall_cycles_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (1'b0),
    .inc_i   (if_id_flush_o),
    .count_o (flush_count_o)
  );

  // Counts frozen cycles of the current access; the entry cycle in RUN already counts as one.
  sat_counter #(.WIDTH(WAIT_W), .MAX(WAIT_W'(MEM_TIMEOUT))) u_wait_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (state_d != ST_MEM_WAIT),
    .inc_i   (state_d == ST_MEM_WAIT),
    .count_o (wait_cnt)
  );

endmodule
